// File: rtl/score_pkg.sv
// Shared types and widths for the game score counter and the downstream tracker.
package score_pkg;
  localparam int SCORE_W   = 7;
  localparam int ID_W      = 3;
  localparam int SCORE_MAX = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    REQ  = 2'd2
  } gsc_state_t;
endpackage

// File: rtl/score_sat_add.sv
// Combinational 7-bit + 2-bit adder, widened to 8 bits then clamped to SCORE_MAX.
module score_sat_add
  import score_pkg::*;
(
  input  logic [SCORE_W-1:0] a_i,
  input  logic [1:0]         b_i,
  output logic [SCORE_W-1:0] sum_o
);
  logic [SCORE_W:0] wide;

  assign wide  = {1'b0, a_i} + {{(SCORE_W-1){1'b0}}, b_i};
  assign sum_o = (wide > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : wide[SCORE_W-1:0];
endmodule

// File: rtl/game_score_counter.sv
// Per-player hit/miss score counter that hands the final score to the tracker via a held request.
// Optional build macro: SCORE_STREAK_BONUS_EN (fourth and later consecutive hits score 2).
module game_score_counter
  import score_pkg::*;
#(
  parameter int ROUNDS      = 10,
  parameter int REQ_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_start,
  input  logic               hit,
  input  logic               miss,
  input  logic [ID_W-1:0]    player_in,
  input  logic               guest_in,
  input  logic               valid,
  output logic [SCORE_W-1:0] score,
  output logic [ID_W-1:0]    playerID,
  output logic               isGuest,
  output logic               score_req,
  output logic               busy,
  output logic               req_timeout
);
  localparam int TMO_W = $clog2(REQ_TIMEOUT + 1);

  gsc_state_t         state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [6:0]         round_q, round_d;
  logic [ID_W-1:0]    player_q, player_d;
  logic               guest_q, guest_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               tmo_flag_q, tmo_flag_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic               ev_hit, ev_any;
  logic [1:0]         add_amt;
  logic [SCORE_W-1:0] score_sum;

  assign ev_hit = hit & ~miss;
  assign ev_any = hit | miss;

`ifdef SCORE_STREAK_BONUS_EN
  logic [1:0] streak_q, streak_d;
  assign add_amt = (streak_q == 2'd3) ? 2'd2 : 2'd1;
`else
  assign add_amt = 2'd1;
`endif

  score_sat_add u_add (
    .a_i   (score_q),
    .b_i   (add_amt),
    .sum_o (score_sum)
  );

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    round_d    = round_q;
    player_d   = player_q;
    guest_d    = guest_q;
    req_d      = req_q;
    busy_d     = busy_q;
    tmo_flag_d = tmo_flag_q;
    tmo_cnt_d  = tmo_cnt_q;
`ifdef SCORE_STREAK_BONUS_EN
    streak_d   = streak_q;
`endif
    // A start is honoured in IDLE and PLAY alike; any same-cycle event is dropped.
    if (game_start && (state_q != REQ)) begin
      state_d    = PLAY;
      score_d    = '0;
      round_d    = '0;
      player_d   = player_in;
      guest_d    = guest_in;
      busy_d     = 1'b1;
      tmo_flag_d = 1'b0;
`ifdef SCORE_STREAK_BONUS_EN
      streak_d   = '0;
`endif
    end else begin
      case (state_q)
        PLAY: begin
          if (ev_any) begin
            round_d = round_q + 7'd1;
            if (ev_hit) score_d = score_sum;
`ifdef SCORE_STREAK_BONUS_EN
            streak_d = ev_hit ? ((streak_q == 2'd3) ? 2'd3 : streak_q + 2'd1) : 2'd0;
`endif
            if (round_q + 7'd1 == 7'(ROUNDS)) begin
              state_d   = REQ;
              req_d     = 1'b1;
              tmo_cnt_d = '0;
            end
          end
        end
        REQ: begin
          if (valid) begin
            state_d = IDLE;
            req_d   = 1'b0;
            busy_d  = 1'b0;
          end else if (tmo_cnt_q == TMO_W'(REQ_TIMEOUT - 1)) begin
            state_d    = IDLE;
            req_d      = 1'b0;
            busy_d     = 1'b0;
            tmo_flag_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end
        IDLE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      score_q    <= '0;
      round_q    <= '0;
      player_q   <= '0;
      guest_q    <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      tmo_flag_q <= 1'b0;
      tmo_cnt_q  <= '0;
`ifdef SCORE_STREAK_BONUS_EN
      streak_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      round_q    <= round_d;
      player_q   <= player_d;
      guest_q    <= guest_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      tmo_flag_q <= tmo_flag_d;
      tmo_cnt_q  <= tmo_cnt_d;
`ifdef SCORE_STREAK_BONUS_EN
      streak_q   <= streak_d;
`endif
    end
  end

  assign score       = score_q;
  assign playerID    = player_q;
  assign isGuest     = guest_q;
  assign score_req   = req_q;
  assign busy        = busy_q;
  assign req_timeout = tmo_flag_q;
endmodule

// File: tb/tb_game_score_counter.sv
// Directed and randomized bench for game_score_counter against an event-list score model.
module tb_game_score_counter;
`ifdef SCORE_STREAK_BONUS_EN
  localparam bit BONUS = 1'b1;
`else
  localparam bit BONUS = 1'b0;
`endif
  localparam int ROUNDS_A = 10;

  logic clk = 1'b0;
  logic rst;
  logic game_start, hit, miss, valid;
  logic [2:0] player_in;
  logic guest_in;
  logic [6:0] score;
  logic [2:0] playerID;
  logic isGuest, score_req, busy, req_timeout;

  logic b_game_start, b_hit, b_miss, b_valid;
  logic [6:0] b_score;
  logic [2:0] b_playerID;
  logic b_isGuest, b_score_req, b_busy, b_req_timeout;

  int total = 0;
  int bad   = 0;

  int exp_score, exp_run, exp_rounds, exp_pid, exp_guest, exp_req, exp_busy;

  always #5 clk = ~clk;

  game_score_counter #(.ROUNDS(ROUNDS_A), .REQ_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .game_start(game_start), .hit(hit), .miss(miss),
    .player_in(player_in), .guest_in(guest_in), .valid(valid),
    .score(score), .playerID(playerID), .isGuest(isGuest),
    .score_req(score_req), .busy(busy), .req_timeout(req_timeout)
  );

  game_score_counter #(.ROUNDS(127), .REQ_TIMEOUT(16)) dut_sat (
    .clk(clk), .rst(rst), .game_start(b_game_start), .hit(b_hit), .miss(b_miss),
    .player_in(player_in), .guest_in(guest_in), .valid(b_valid),
    .score(b_score), .playerID(b_playerID), .isGuest(b_isGuest),
    .score_req(b_score_req), .busy(b_busy), .req_timeout(b_req_timeout)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Score value of a hit given how many hits directly preceded it.
  function automatic int hit_points(input int run);
    return (BONUS && run >= 3) ? 2 : 1;
  endfunction

  task automatic m_start(input int p, input int g);
    exp_score = 0; exp_run = 0; exp_rounds = 0;
    exp_pid = p; exp_guest = g; exp_req = 0; exp_busy = 1;
  endtask

  task automatic m_event(input bit h, input bit m);
    if (exp_busy == 1 && exp_req == 0 && (h || m)) begin
      if (h && !m) begin
        exp_score = exp_score + hit_points(exp_run);
        if (exp_score > 127) exp_score = 127;
        exp_run++;
      end else begin
        exp_run = 0;
      end
      exp_rounds++;
      if (exp_rounds == ROUNDS_A) exp_req = 1;
    end
  endtask

  task automatic start_game(input int p, input int g);
    player_in = 3'(p); guest_in = g[0]; game_start = 1'b1;
    tick;
    game_start = 1'b0;
    m_start(p, g);
    chk("start_busy", busy, 1);
    chk("start_score", score, 0);
    chk("start_pid", playerID, exp_pid);
    chk("start_guest", isGuest, exp_guest);
    chk("start_tmo_clr", req_timeout, 0);
  endtask

  task automatic event_a(input bit h, input bit m);
    hit = h; miss = m;
    tick;
    hit = 1'b0; miss = 1'b0;
    m_event(h, m);
    chk("ev_score", score, exp_score);
    chk("ev_req", score_req, exp_req);
  endtask

  task automatic ack(input int delay);
    for (int i = 0; i < delay; i++) begin
      tick;
      chk("ack_hold", score_req, 1);
    end
    valid = 1'b1;
    tick;
    valid = 1'b0;
    exp_req = 0; exp_busy = 0;
    chk("ack_req_fall", score_req, 0);
    chk("ack_busy", busy, 0);
    chk("ack_score_hold", score, exp_score);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cyc, sat_exp, sat_run;
    rst = 1'b1; game_start = 0; hit = 0; miss = 0; valid = 0;
    player_in = 0; guest_in = 0;
    b_game_start = 0; b_hit = 0; b_miss = 0; b_valid = 0;
    tick; tick;
    chk("rst_score", score, 0);
    chk("rst_pid", playerID, 0);
    chk("rst_guest", isGuest, 0);
    chk("rst_req", score_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tmo", req_timeout, 0);
    chk("rst_b_score", b_score, 0);
    #2 rst = 1'b0;
    tick;
    hit = 1'b1; tick; hit = 1'b0;
    chk("idle_hit_ignored", score, 0);

    // Basic game: alternating hit/miss, ack two cycles after the request.
    start_game(5, 0);
    for (int i = 0; i < ROUNDS_A; i++) event_a(i % 2 == 0, i % 2 == 1);
    chk("basic_score", score, 5);
    chk("basic_pid", playerID, 5);
    chk("basic_req", score_req, 1);
    ack(1);

    // Simultaneous hit+miss and restart mid-game.
    start_game(3, 1);
    event_a(1, 1);
    chk("both_no_point", score, 0);
    for (int i = 0; i < 3; i++) event_a(1, 0);
    chk("three_hits", score, 3);
    player_in = 3'd6; guest_in = 1'b0; game_start = 1'b1; hit = 1'b1;
    tick;
    game_start = 1'b0; hit = 1'b0;
    m_start(6, 0);
    chk("restart_score", score, 0);
    chk("restart_pid", playerID, 6);
    chk("restart_guest", isGuest, 0);
    for (int i = 0; i < ROUNDS_A; i++) event_a(1, 0);
    chk("restart_full_score", score, BONUS ? 17 : 10);
    ack(0);

    // Streak pattern: five hits then five misses.
    start_game(1, 0);
    for (int i = 0; i < 5; i++) event_a(1, 0);
    for (int i = 0; i < 5; i++) event_a(0, 1);
    chk("streak_score", score, BONUS ? 7 : 5);
    ack(2);

    // Timeout with no ack; a hit inside REQ must not move the score.
    start_game(4, 1);
    for (int i = 0; i < ROUNDS_A; i++) event_a(0, 1);
    n = 0;
    while (score_req === 1'b1 && n < 40) begin
      n++;
      hit = (n == 1);
      tick;
      hit = 1'b0;
      chk("tmo_score_frozen", score, exp_score);
    end
    chk("tmo_req_cycles", n, 16);
    chk("tmo_flag", req_timeout, 1);
    chk("tmo_busy", busy, 0);
    start_game(2, 0);
    for (int i = 0; i < ROUNDS_A; i++) event_a(1, 0);
    ack(0);

    // Randomized games checked cycle by cycle.
    for (int g = 0; g < 4; g++) begin
      start_game(int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
      cyc = 0;
      while (exp_req == 0 && cyc < 200) begin
        case ($urandom_range(0, 4))
          0:       event_a(0, 0);
          1, 2:    event_a(1, 0);
          3:       event_a(0, 1);
          default: event_a(1, 1);
        endcase
        cyc++;
      end
      chk("rand_reached_req", exp_req, 1);
      chk("rand_pid", playerID, exp_pid);
      chk("rand_guest", isGuest, exp_guest);
      ack(int'($urandom_range(0, 3)));
    end

    // Saturation on a 127-round instance.
    b_game_start = 1'b1; tick; b_game_start = 1'b0;
    sat_exp = 0; sat_run = 0;
    for (int i = 0; i < 127; i++) begin
      b_hit = 1'b1; tick; b_hit = 1'b0;
      sat_exp = sat_exp + hit_points(sat_run);
      if (sat_exp > 127) sat_exp = 127;
      sat_run++;
      chk("sat_score", b_score, sat_exp);
    end
    chk("sat_final", b_score, 127);
    chk("sat_req", b_score_req, 1);
    b_valid = 1'b1; tick; b_valid = 1'b0;
    chk("sat_req_fall", b_score_req, 0);

    // Reset mid-REQ; a start pulse inside REQ is ignored first.
    start_game(7, 1);
    for (int i = 0; i < ROUNDS_A; i++) event_a(1, 0);
    player_in = 3'd2; guest_in = 1'b0; game_start = 1'b1;
    tick;
    game_start = 1'b0;
    chk("req_start_ignored_pid", playerID, 7);
    chk("req_start_ignored_req", score_req, 1);
    chk("req_start_ignored_score", score, exp_score);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", score_req, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_score", score, 0);
    #1 rst = 1'b0;
    tick;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_req", score_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
